// File: rtl/matmul_pkg.sv
// matmul_pkg: shared widths and FSM encoding for the matrix-multiply sequencer
package matmul_pkg;
    localparam int DIM_DEF = 4;
    localparam int DATA_W = 8;
    localparam int ACC_W = 32;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;
endpackage

// File: rtl/matmul_index_counter.sv
// matmul_index_counter: nested i/j/k walk over a DIM^3 product, k innermost
module matmul_index_counter #(
    parameter int DIM = 4,
    parameter int IDX_W = $clog2(DIM)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_advance,
    output logic [IDX_W-1:0] o_i,
    output logic [IDX_W-1:0] o_j,
    output logic [IDX_W-1:0] o_k,
    output logic             o_last
);
    logic [IDX_W-1:0] r_i, r_j, r_k;
    logic w_i_last, w_j_last, w_k_last;
    assign w_i_last = r_i == IDX_W'(DIM - 1);
    assign w_j_last = r_j == IDX_W'(DIM - 1);
    assign w_k_last = r_k == IDX_W'(DIM - 1);
    assign o_last = w_i_last & w_j_last & w_k_last;
    assign o_i = r_i;
    assign o_j = r_j;
    assign o_k = r_k;
    // DIM is a power of two, so each index wraps to zero on its own
    always_ff @(posedge clk) begin
        if (!reset || i_clear) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else if (i_advance) begin
            r_k <= r_k + IDX_W'(1);
            if (w_k_last) begin
                r_j <= r_j + IDX_W'(1);
                if (w_j_last) r_i <= r_i + IDX_W'(1);
            end
        end
    end
endmodule

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: walks C = A x B, feeds the MAC one product per cycle and writes each dot product to C
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int DIM = DIM_DEF,
    parameter int ADDR_W = $clog2(DIM * DIM)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] a_rdata,
    input  logic [DATA_W-1:0] b_rdata,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    output logic              mac_enable,
    output logic              mac_start,
    input  logic [ACC_W-1:0]  mac_acc,
    output logic              c_we,
    output logic [ADDR_W-1:0] c_addr,
    output logic [ACC_W-1:0]  c_wdata
);
    localparam int IDX_W = $clog2(DIM);
    state_t r_state, w_next;
    logic r_drain;
    logic w_run, w_last;
    logic [IDX_W-1:0] w_i, w_j, w_k;
    logic r_v1, r_first1, r_last1, r_v2;
    logic [ADDR_W-1:0] r_cidx1, r_cidx2;
    assign w_run = r_state == ST_RUN;
    matmul_index_counter #(.DIM(DIM), .IDX_W(IDX_W)) u_idx (
        .clk(clk),
        .reset(reset),
        .i_clear(r_state == ST_IDLE && start),
        .i_advance(w_run),
        .o_i(w_i),
        .o_j(w_j),
        .o_k(w_k),
        .o_last(w_last)
    );
    // Row-major addresses reduce to index concatenation because DIM is a power of two
    assign a_addr = ADDR_W'({w_i, w_k});
    assign b_addr = ADDR_W'({w_k, w_j});
    assign mac_a = a_rdata;
    assign mac_b = b_rdata;
    assign mac_enable = r_v1;
    assign mac_start = r_v1 & r_first1;
    assign c_we = r_v2;
    assign c_addr = r_cidx2;
    assign c_wdata = mac_acc;
    always_comb begin
        w_next = r_state;
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            ST_IDLE:  w_next = start ? ST_RUN : ST_IDLE;
            ST_RUN: begin
                busy = 1'b1;
                w_next = w_last ? ST_DRAIN : ST_RUN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                w_next = r_drain ? ST_DONE : ST_DRAIN;
            end
            default: begin
                done = 1'b1;
                w_next = ST_IDLE;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_drain <= 1'b0;
        end else begin
            r_state <= w_next;
            r_drain <= (r_state == ST_DRAIN) ? ~r_drain : 1'b0;
        end
    end
    // Stage 1 lines up with the memory read; stage 2 lines up with the MAC accumulator
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_v1 <= 1'b0;
            r_first1 <= 1'b0;
            r_last1 <= 1'b0;
            r_cidx1 <= '0;
            r_v2 <= 1'b0;
            r_cidx2 <= '0;
        end else begin
            r_v1 <= w_run;
            r_first1 <= w_k == '0;
            r_last1 <= w_k == IDX_W'(DIM - 1);
            r_cidx1 <= ADDR_W'({w_i, w_j});
            r_v2 <= r_v1 & r_last1;
            r_cidx2 <= r_cidx1;
        end
    end
endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: scoreboard bench with operand memories and a signed MAC model around DIM=2 and DIM=4 instances
module tb_matmul_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int cyc = 0;
    int total = 0;
    int bad = 0;
    bit mon_on = 1'b0;

    logic start2 = 1'b0, busy2, done2, en2, st2, c_we2;
    logic [1:0] a_addr2, b_addr2, c_addr2;
    logic [7:0] a_rd2, b_rd2, mac_a2, mac_b2;
    logic [31:0] acc2, c_wdata2;
    logic start4 = 1'b0, busy4, done4, en4, st4, c_we4;
    logic [3:0] a_addr4, b_addr4, c_addr4;
    logic [7:0] a_rd4, b_rd4, mac_a4, mac_b4;
    logic [31:0] acc4, c_wdata4;
    logic [7:0] ma2[4], mb2[4], ma4[16], mb4[16];

    typedef struct {int n; int cyc; logic [31:0] addr; logic [31:0] data;} wr_t;
    typedef struct {int n; int cyc;} dn_t;
    wr_t wq[$];
    dn_t dq[$];
    int bs[2] = '{1, 1}, be[2] = '{0, 0}, fs[2] = '{1, 1}, fe[2] = '{0, 0}, dimv[2] = '{2, 4};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    matmul_sequencer #(.DIM(2)) dut2 (
        .clk(clk), .reset(rst_n), .start(start2), .busy(busy2), .done(done2),
        .a_addr(a_addr2), .b_addr(b_addr2), .a_rdata(a_rd2), .b_rdata(b_rd2),
        .mac_a(mac_a2), .mac_b(mac_b2), .mac_enable(en2), .mac_start(st2),
        .mac_acc(acc2), .c_we(c_we2), .c_addr(c_addr2), .c_wdata(c_wdata2)
    );
    matmul_sequencer #(.DIM(4)) dut4 (
        .clk(clk), .reset(rst_n), .start(start4), .busy(busy4), .done(done4),
        .a_addr(a_addr4), .b_addr(b_addr4), .a_rdata(a_rd4), .b_rdata(b_rd4),
        .mac_a(mac_a4), .mac_b(mac_b4), .mac_enable(en4), .mac_start(st4),
        .mac_acc(acc4), .c_we(c_we4), .c_addr(c_addr4), .c_wdata(c_wdata4)
    );

    function automatic logic [31:0] mul(logic [7:0] a, logic [7:0] b);
        int x, y;
        x = $signed(a);
        y = $signed(b);
        return 32'(x * y);
    endfunction

    always @(posedge clk) begin
        if (en2) acc2 <= (st2 ? 32'd0 : acc2) + mul(mac_a2, mac_b2);
        if (en4) acc4 <= (st4 ? 32'd0 : acc4) + mul(mac_a4, mac_b4);
        a_rd2 <= ma2[a_addr2];
        b_rd2 <= mb2[b_addr2];
        a_rd4 <= ma4[a_addr4];
        b_rd4 <= mb4[b_addr4];
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] ael(int n, int idx);
        if (n == 0) return ma2[idx];
        return ma4[idx];
    endfunction

    function automatic logic [7:0] bel(int n, int idx);
        if (n == 0) return mb2[idx];
        return mb4[idx];
    endfunction

    task automatic plan(int n, int dim, int s, int ab);
        int last_fe;
        for (int e = 0; e < dim * dim; e++) begin
            int i = e / dim, j = e % dim, w = s + e * dim + dim + 2;
            logic [31:0] sum = 32'd0;
            for (int k = 0; k < dim; k++) sum += mul(ael(n, i * dim + k), bel(n, k * dim + j));
            if (ab == 0 || w <= ab) wq.push_back('{n, w, 32'(e), sum});
        end
        if (ab == 0) dq.push_back('{n, s + dim * dim * dim + 3});
        last_fe = s + 1 + dim * dim * dim;
        bs[n] = s + 1;
        be[n] = (ab != 0) ? ab : s + dim * dim * dim + 2;
        fs[n] = s + 2;
        fe[n] = (ab != 0 && ab < last_fe) ? ab : last_fe;
        dimv[n] = dim;
    endtask

    task automatic set_start(int n, logic v);
        if (n == 0) start2 = v;
        else start4 = v;
    endtask

    task automatic run(int n, int dim, int restart_off, int abort_off);
        int s;
        @(posedge clk);
        #1;
        s = cyc;
        plan(n, dim, s, (abort_off > 0) ? s + abort_off : 0);
        set_start(n, 1'b1);
        @(posedge clk);
        #1;
        while (cyc < s + dim * dim * dim + 3) begin
            set_start(n, restart_off > 0 && cyc == s + restart_off);
            rst_n = !(abort_off > 0 && cyc == s + abort_off);
            @(posedge clk);
            #1;
        end
        set_start(n, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic mon(int n, logic we, logic [31:0] ad, logic [31:0] dt, logic dn, logic bz, logic en, logic st);
        logic exp_en;
        if (we) begin
            if (wq.size() == 0) chk("c_we_spurious", 32'(we), 32'd0);
            else begin
                wr_t e = wq.pop_front();
                chk("wr_inst", n, e.n);
                chk("wr_cycle", cyc, e.cyc);
                chk("c_addr", ad, e.addr);
                chk("c_wdata", dt, e.data);
            end
        end
        if (dn) begin
            if (dq.size() == 0) chk("done_spurious", 32'(dn), 32'd0);
            else begin
                dn_t d = dq.pop_front();
                chk("done_inst", n, d.n);
                chk("done_cycle", cyc, d.cyc);
            end
        end
        chk("busy", 32'(bz), 32'(cyc >= bs[n] && cyc <= be[n]));
        exp_en = cyc >= fs[n] && cyc <= fe[n];
        chk("mac_enable", 32'(en), 32'(exp_en));
        chk("mac_start", 32'(st), 32'(exp_en && ((cyc - fs[n]) % dimv[n] == 0)));
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            mon(0, c_we2, {30'd0, c_addr2}, c_wdata2, done2, busy2, en2, st2);
            mon(1, c_we4, {28'd0, c_addr4}, c_wdata4, done4, busy4, en4, st4);
        end
    end

    initial begin
        ma2 = '{8'd1, 8'd2, 8'd3, 8'd4};
        mb2 = '{8'd5, 8'd6, 8'd7, 8'd8};
        foreach (ma4[x]) begin
            ma4[x] = 8'h80;
            mb4[x] = 8'h80;
        end
        repeat (2) @(posedge clk);
        #1;
        mon_on = 1'b1;
        chk("rst_a_addr", {30'd0, a_addr2}, 32'd0);
        chk("rst_b_addr", {30'd0, b_addr2}, 32'd0);
        chk("rst_c_we", 32'(c_we2), 32'd0);
        chk("rst_a_addr4", {28'd0, a_addr4}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(0, 2, 0, 0);
        chk("c_ref00", wq.size(), 0);
        run(0, 2, 5, 0);
        run(0, 2, 0, 0);
        ma2 = '{8'hFF, 8'd2, 8'hFD, 8'd4};
        mb2 = '{8'd1, 8'd0, 8'd0, 8'd1};
        run(0, 2, 0, 0);
        ma2 = '{8'd1, 8'd2, 8'd3, 8'd4};
        mb2 = '{8'd5, 8'd6, 8'd7, 8'd8};
        run(0, 2, 0, 5);
        run(0, 2, 0, 0);
        run(1, 4, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("writes_left", wq.size(), 0);
        chk("dones_left", dq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
